// File: rtl/mult_scale_pkg.sv
// Shared constants and the pipeline-stage record for the multiply-and-scale arbiter.
// Default scale pair 5243 / 2^21 approximates division by 400.
package mult_scale_pkg;

  localparam int DATA_W           = 32;
  localparam int PROD_W           = 64;
  localparam int PERF_CNT_W       = 16;
  localparam int MUL_W            = 13;
  localparam int ID_MAX_W         = 3;
  localparam int SCALE_MUL_DFLT   = 5243;
  localparam int SCALE_SHIFT_DFLT = 21;

  // id is sized for the largest supported requester count; data carries the full product
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [PROD_W-1:0]   data;
  } stage_t;

endpackage

// File: rtl/mult_scale_pipe.sv
// Two-stage core: S1 full a*b product, S2 (prod*SCALE_MUL)>>SCALE_SHIFT truncated to 32 bits.
// Latency 2 enabled edges; no backpressure, en=0 freezes both stages.
module mult_scale_pipe
  import mult_scale_pkg::*;
#(
  parameter int ID_W        = 2,
  parameter int SCALE_MUL   = SCALE_MUL_DFLT,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DFLT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [ID_W-1:0]   in_id,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  output logic              out_valid,
  output logic [ID_W-1:0]   out_id,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  localparam int WIDE_W = PROD_W + MUL_W;

  stage_t            s1_q;
  stage_t            s2_q;
  logic [WIDE_W-1:0] scaled;
  logic              unused_bits;

  assign scaled = (WIDE_W'(s1_q.data) * WIDE_W'(SCALE_MUL)) >> SCALE_SHIFT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (en) begin
      s1_q.valid <= in_valid;
      // operand registers only move on a real request so idle cycles do not toggle the multiplier
      if (in_valid) begin
        s1_q.id   <= ID_MAX_W'(in_id);
        s1_q.data <= PROD_W'(dataa) * PROD_W'(datab);
      end
      s2_q.valid <= s1_q.valid;
      s2_q.id    <= s1_q.id;
      s2_q.data  <= PROD_W'(scaled[DATA_W-1:0]);
    end
  end

  assign out_valid   = s2_q.valid;
  assign out_id      = s2_q.id[ID_W-1:0];
  assign result      = s2_q.data[DATA_W-1:0];
  assign busy        = s1_q.valid | s2_q.valid;
  assign unused_bits = ^{scaled, s2_q};

endmodule

// File: rtl/mult_scale_arbiter.sv
// Round-robin arbiter in front of the shared multiply-and-scale core; response 2 edges after accept, no response backpressure.
// Optional per-requester accept counters (perf_clr/perf_grants) under MULT_SCALE_ARB_PERF_EN.
module mult_scale_arbiter
  import mult_scale_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SCALE_MUL   = SCALE_MUL_DFLT,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DFLT,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_dataa,
  input  logic [NUM_REQ*DATA_W-1:0]   req_datab,
  output logic                        resp_valid,
  output logic [ID_W-1:0]             resp_id,
  output logic [DATA_W-1:0]           resp_result,
`ifdef MULT_SCALE_ARB_PERF_EN
  input  logic                        perf_clr,
  output logic [NUM_REQ*PERF_CNT_W-1:0] perf_grants,
`endif
  output logic                        busy
);

  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   grant;
  logic              any_req;
  logic              accept;
  logic              core_valid;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  // search begins just past the last winner so every requester is reached within NUM_REQ accepts
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        grant   = ID_W'(idx);
      end
    end
  end

  assign accept    = en & any_req;
  assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;
  assign sel_a     = req_dataa[DATA_W*grant +: DATA_W];
  assign sel_b     = req_datab[DATA_W*grant +: DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      ptr_q <= grant;
    end
  end

  mult_scale_pipe #(
    .ID_W        (ID_W),
    .SCALE_MUL   (SCALE_MUL),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .in_valid  (accept),
    .in_id     (grant),
    .dataa     (sel_a),
    .datab     (sel_b),
    .out_valid (core_valid),
    .out_id    (resp_id),
    .result    (resp_result),
    .busy      (busy)
  );

  // a response held during en=0 is re-presented once en returns
  assign resp_valid = core_valid & en;

`ifdef MULT_SCALE_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (en) begin
      if (perf_clr) begin
        for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else if (accept) begin
        cnt_q[grant] <= cnt_q[grant] + PERF_CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
    assign perf_grants[PERF_CNT_W*i +: PERF_CNT_W] = cnt_q[i];
  end
`else
  // accept counters are not built in this configuration
`endif

endmodule
